// File: rtl/systolic_pkg.sv
// Shared constants, FSM state type and bus lane helpers for the 4x4 systolic controller.
package systolic_pkg;

  localparam int unsigned OperandW = 16;
  localparam int unsigned AccW     = 33;
  localparam int unsigned ArrN     = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StClear,
    StFeed,
    StDrain,
    StOut
  } state_e;

  // Lane idx of a packed 4-lane operand bus.
  function automatic logic [OperandW-1:0] lane_dw(input logic [ArrN*OperandW-1:0] bus,
                                                  input int unsigned idx);
    return bus[idx*OperandW +: OperandW];
  endfunction

  // Row of a packed row-major 4x4 accumulator bus (4 lanes, column j in lane j).
  function automatic logic [ArrN*AccW-1:0] row_cw(input logic [ArrN*ArrN*AccW-1:0] bus,
                                                 input int unsigned row);
    return bus[row*ArrN*AccW +: ArrN*AccW];
  endfunction

endpackage

// File: rtl/skew_feeder.sv
// One edge lane: K-deep operand buffer plus a delayed read that emits zero outside its window.
module skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned KMAX = 16,
  parameter int unsigned DW   = 16,
  parameter int unsigned IW   = 4,
  parameter int unsigned KW   = 5,
  parameter int unsigned TW   = 6,
  parameter int unsigned LANE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic          feed_on,
  input  logic [TW-1:0] feed_t,
  input  logic [KW-1:0] k,
  output logic [DW-1:0] feed_data
);

  logic [DW-1:0] mem_q [KMAX];
  logic [DW-1:0] feed_d, feed_q;
  logic [TW-1:0] rel;
  logic          hit;

  // Buffer write port; cleared on reset so an aborted job leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < int'(KMAX); e++) mem_q[e] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Lane is delayed by its index; guard t < LANE before subtracting.
  always_comb begin
    rel    = feed_t - TW'(LANE);
    hit    = feed_on && (feed_t >= TW'(LANE)) && (rel < TW'(k));
    feed_d = hit ? mem_q[rel[IW-1:0]] : '0;
  end

  // Registered edge feed; inputs describe the next cycle's t.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) feed_q <= '0;
    else      feed_q <= feed_d;
  end

  assign feed_data = feed_q;

endmodule

// File: rtl/systolic_ctrl4x4.sv
// Job sequencer for the 4x4 output-stationary systolic array: load, clear, skewed feed,
// drain, capture and row-by-row result streaming.
module systolic_ctrl4x4
  import systolic_pkg::*;
#(
  parameter int unsigned KMAX      = 16,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned DW        = OperandW,
  parameter int unsigned CW        = AccW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       cfg_k,
  output logic             busy,
  output logic             err,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [4*DW-1:0]  ld_a,
  input  logic [4*DW-1:0]  ld_b,
  output logic             arr_clr,
  output logic [4*DW-1:0]  arr_a,
  output logic [4*DW-1:0]  arr_b,
  input  logic [16*CW-1:0] arr_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_row,
  output logic [4*CW-1:0]  res_data,
  output logic             done
);

  localparam int unsigned IW  = $clog2(KMAX);
  localparam int unsigned KW  = 5;
  localparam int unsigned TW  = $clog2(KMAX + 3) + 1;
  localparam int unsigned DCW = $clog2(DRAIN_CYC + 1);

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [KW-1:0]  kidx_q, kidx_d;
  logic [TW-1:0]  t_q, t_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [1:0]     r_q, r_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic [16*CW-1:0] res_q, res_d;
  logic           ld_wr;
  logic           capture;
  logic           feed_on;

  // Next-state logic for the job FSM and its counters.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    kidx_d  = kidx_q;
    t_d     = t_q;
    dcnt_d  = dcnt_q;
    r_d     = r_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    capture = 1'b0;
    ld_wr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_k != '0 && 32'(cfg_k) <= KMAX) begin
            k_d     = cfg_k;
            kidx_d  = '0;
            state_d = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (ld_valid) begin
          ld_wr  = 1'b1;
          kidx_d = kidx_q + 5'd1;
          if (kidx_q == k_q - 5'd1) state_d = StClear;
        end
      end
      StClear: begin
        t_d     = '0;
        state_d = StFeed;
      end
      StFeed: begin
        t_d = t_q + TW'(1);
        if (t_q == TW'(k_q) + TW'(2)) begin
          dcnt_d  = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        dcnt_d = dcnt_q + DCW'(1);
        if (dcnt_q == DCW'(DRAIN_CYC - 1)) begin
          capture = 1'b1;
          r_d     = '0;
          state_d = StOut;
        end
      end
      StOut: begin
        if (res_ready) begin
          r_d = r_q + 2'd1;
          if (r_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    res_d = capture ? arr_c : res_q;
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      kidx_q  <= '0;
      t_q     <= '0;
      dcnt_q  <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      kidx_q  <= kidx_d;
      t_q     <= t_d;
      dcnt_q  <= dcnt_d;
      r_q     <= r_d;
      err_q   <= err_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  // Feeders look at the next state so their registered output lines up with t.
  assign feed_on = (state_d == StFeed);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    skew_feeder #(
      .KMAX (KMAX),
      .DW   (DW),
      .IW   (IW),
      .KW   (KW),
      .TW   (TW),
      .LANE (g)
    ) u_feed_a (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (ld_wr),
      .wr_idx    (kidx_q[IW-1:0]),
      .wr_data   (lane_dw(ld_a, g)),
      .feed_on   (feed_on),
      .feed_t    (t_d),
      .k         (k_q),
      .feed_data (arr_a[g*DW +: DW])
    );

    skew_feeder #(
      .KMAX (KMAX),
      .DW   (DW),
      .IW   (IW),
      .KW   (KW),
      .TW   (TW),
      .LANE (g)
    ) u_feed_b (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (ld_wr),
      .wr_idx    (kidx_q[IW-1:0]),
      .wr_data   (lane_dw(ld_b, g)),
      .feed_on   (feed_on),
      .feed_t    (t_d),
      .k         (k_q),
      .feed_data (arr_b[g*DW +: DW])
    );
  end

  // Status and result outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != StIdle);
    ld_ready  = (state_q == StLoad);
    arr_clr   = (state_q == StClear);
    res_valid = (state_q == StOut);
    res_row   = r_q;
    res_data  = res_valid ? row_cw(res_q, 32'(r_q)) : '0;
    err       = err_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_systolic_ctrl4x4.sv
// Directed bench for systolic_ctrl4x4 with a behavioural 4x4 PE array and a result scoreboard.
module tb_systolic_ctrl4x4;

  localparam int DW = 16;
  localparam int CW = 33;
  localparam int RW = 4 * CW;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [4:0]       cfg_k = '0;
  logic             busy, err, ld_ready, arr_clr, res_valid, done;
  logic             ld_valid = 1'b0;
  logic [4*DW-1:0]  ld_a = '0;
  logic [4*DW-1:0]  ld_b = '0;
  logic [4*DW-1:0]  arr_a, arr_b;
  logic [16*CW-1:0] arr_c;
  logic             res_ready = 1'b0;
  logic [1:0]       res_row;
  logic [4*CW-1:0]  res_data;

  systolic_ctrl4x4 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_k     (cfg_k),
    .busy      (busy),
    .err       (err),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .arr_clr   (arr_clr),
    .arr_a     (arr_a),
    .arr_b     (arr_b),
    .arr_c     (arr_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_row   (res_row),
    .res_data  (res_data),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural output-stationary array: operands hop east/south one PE per cycle.
  logic [CW-1:0] acc [4][4];
  logic [DW-1:0] ar  [4][4];
  logic [DW-1:0] br  [4][4];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          acc[i][j] <= '0;
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
        end
    end else begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          logic [DW-1:0] ain, bin;
          ain = (j == 0) ? arr_a[i*DW +: DW] : ar[i][j-1];
          bin = (i == 0) ? arr_b[j*DW +: DW] : br[i-1][j];
          ar[i][j]  <= ain;
          br[i][j]  <= bin;
          acc[i][j] <= arr_clr ? '0 : acc[i][j] + CW'(ain) * CW'(bin);
        end
    end
  end

  always_comb begin
    arr_c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) arr_c[(i*4+j)*CW +: CW] = acc[i][j];
  end

  typedef struct packed {
    logic [1:0]    row;
    logic [RW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   clr_cnt = 0;
  int   feed_cnt = 0;

  logic [DW-1:0] ma [4][16];
  logic [DW-1:0] mb [16][4];

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard side: every valid result row must match the head entry; pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt <= done_cnt + 1;
      if (arr_clr) clr_cnt <= clr_cnt + 1;
      if ((arr_a | arr_b) != '0) feed_cnt <= feed_cnt + 1;
      if (res_valid) begin
        chk("sb_nonempty", RW'(sb.size() != 0), RW'(1));
        if (sb.size() != 0) begin
          chk("res_row", RW'(res_row), RW'(sb[0].row));
          chk("res_data", res_data, sb[0].data);
          if (res_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] exp_row(input int k, input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      logic [CW-1:0] s;
      s = '0;
      for (int kk = 0; kk < k; kk++) s = s + CW'(ma[r][kk]) * CW'(mb[kk][j]);
      v[j*CW +: CW] = s;
    end
    return v;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, RW'(busy), RW'(0));
    chk({tag, "_err"}, RW'(err), RW'(0));
    chk({tag, "_ld_ready"}, RW'(ld_ready), RW'(0));
    chk({tag, "_arr_clr"}, RW'(arr_clr), RW'(0));
    chk({tag, "_res_valid"}, RW'(res_valid), RW'(0));
    chk({tag, "_done"}, RW'(done), RW'(0));
    chk({tag, "_arr_a"}, RW'(arr_a), RW'(0));
    chk({tag, "_arr_b"}, RW'(arr_b), RW'(0));
    chk({tag, "_res_row"}, RW'(res_row), RW'(0));
    chk({tag, "_res_data"}, res_data, RW'(0));
  endtask

  task automatic set_rand(input int k);
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < 4; i++) begin
        ma[i][kk] = DW'($urandom_range(0, 65535));
        mb[kk][i] = DW'($urandom_range(0, 65535));
      end
  endtask

  task automatic drive_beat(input int kk);
    for (int i = 0; i < 4; i++) begin
      ld_a[i*DW +: DW] = ma[i][kk];
      ld_b[i*DW +: DW] = mb[kk][i];
    end
    ld_valid = 1'b1;
  endtask

  task automatic reject(input logic [4:0] kval, input string tag);
    start = 1'b1;
    cfg_k = kval;
    step();
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_err"}, RW'(err), RW'(1));
    chk({tag, "_busy"}, RW'(busy), RW'(0));
    chk({tag, "_ld_ready"}, RW'(ld_ready), RW'(0));
    step();
    @(negedge clk);
    chk({tag, "_err_pulse"}, RW'(err), RW'(0));
    chk({tag, "_busy2"}, RW'(busy), RW'(0));
    step();
  endtask

  // One complete job; bp toggles res_ready 0,0,1 and gaps inserts idle load cycles.
  task automatic run_job(input int k, input bit bp, input bit gaps, input bit lat,
                         input bit dense, input bit skew, input string tag);
    int c0, dc, d0, cl0, f0;
    bit got;
    got = 1'b0;
    dc  = 0;
    for (int r = 0; r < 4; r++) sb.push_back('{row: 2'(r), data: exp_row(k, r)});
    d0  = done_cnt;
    cl0 = clr_cnt;
    f0  = feed_cnt;
    start = 1'b1;
    cfg_k = 5'(k);
    c0 = cyc;
    step();
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_ld_ready_lat"}, RW'(ld_ready), RW'(1));
    chk({tag, "_busy"}, RW'(busy), RW'(1));
    for (int kk = 0; kk < k; kk++) begin
      if (gaps && (kk % 2 == 1)) begin
        ld_valid = 1'b0;
        step();
      end
      drive_beat(kk);
      step();
    end
    ld_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_clr"}, RW'(arr_clr), RW'(1));
    chk({tag, "_clr_ld_ready"}, RW'(ld_ready), RW'(0));
    chk({tag, "_clr_a"}, RW'(arr_a), RW'(0));
    if (skew) begin
      step();
      step();
      step();
      @(negedge clk);
      chk({tag, "_skew_a"}, RW'(arr_a), RW'(64'h0000_0000_0001_0000));
      chk({tag, "_skew_b"}, RW'(arr_b), RW'(64'h0000_0003_0006_0009));
      chk({tag, "_skew_clr"}, RW'(arr_clr), RW'(0));
    end
    for (int n = 0; n < 300 && !got; n++) begin
      step();
      res_ready = bp ? (n % 3 == 2) : 1'b1;
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        dc  = cyc;
      end
    end
    chk({tag, "_done_seen"}, RW'(got), RW'(1));
    if (lat) chk({tag, "_latency"}, RW'(dc - c0), RW'(1 + k + 1 + (k + 3) + 4 + 4));
    step();
    res_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, RW'(done), RW'(0));
    chk({tag, "_idle_busy"}, RW'(busy), RW'(0));
    chk({tag, "_sb_drained"}, RW'(sb.size()), RW'(0));
    chk({tag, "_done_count"}, RW'(done_cnt - d0), RW'(1));
    chk({tag, "_clr_count"}, RW'(clr_cnt - cl0), RW'(1));
    if (dense) chk({tag, "_feed_cycles"}, RW'(feed_cnt - f0), RW'(k + 3));
    step();
  endtask

  initial begin
    #1;
    chk_quiet("reset");
    step();
    step();
    rst = 1'b1;
    step();

    reject(5'd0, "k0");
    reject(5'd17, "k17");

    // Identity A, B = 1..16 row-major: results equal B.
    for (int i = 0; i < 4; i++)
      for (int kk = 0; kk < 4; kk++) begin
        ma[i][kk] = (i == kk) ? 16'd1 : 16'd0;
        mb[kk][i] = DW'(kk * 4 + i + 1);
      end
    run_job(4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "ident");

    // k=1 with maximal operands.
    for (int i = 0; i < 4; i++) begin
      ma[i][0] = 16'hFFFF;
      mb[0][i] = 16'hFFFF;
    end
    chk("k1_model", exp_row(1, 2), {4{33'h0_FFFE_0001}});
    run_job(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "k1");

    // Backpressured output and gappy load.
    set_rand(3);
    run_job(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "bp");

    // Full-depth buffer.
    set_rand(16);
    run_job(16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "kmax");

    // Abort in FEED t=3, then a clean k=2 job.
    set_rand(4);
    start = 1'b1;
    cfg_k = 5'd4;
    step();
    start = 1'b0;
    for (int kk = 0; kk < 4; kk++) begin
      drive_beat(kk);
      step();
    end
    ld_valid = 1'b0;
    for (int s = 0; s < 4; s++) step();
    rst = 1'b0;
    #1;
    chk_quiet("abort");
    step();
    rst = 1'b1;
    step();
    set_rand(2);
    run_job(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
